// File: rtl/lsu_pkg.sv
// Shared access-size encodings, FSM states and alignment helper for the MEM-stage LSU.
package lsu_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Unknown encodings are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] ty, input logic [1:0] off);
    case (ty)
      DM_BYTE, DM_BYTE_U: is_misaligned = 1'b0;
      DM_HALF, DM_HALF_U: is_misaligned = off[0];
      default:            is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enables/replication, load extract and extend.
// Zero latency; no flow control of its own.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_type_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    case (st_type_i)
      DM_HALF, DM_HALF_U: begin
        st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
      end
      DM_BYTE, DM_BYTE_U: begin
        st_be_o   = 4'b0001 << st_off_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    byte_lane = ld_data_i[7:0];
      2'd1:    byte_lane = ld_data_i[15:8];
      2'd2:    byte_lane = ld_data_i[23:16];
      default: byte_lane = ld_data_i[31:24];
    endcase
    half_lane = ld_off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    case (ld_type_i)
      DM_HALF:   ld_data_o = {{16{half_lane[15]}}, half_lane};
      DM_HALF_U: ld_data_o = {16'h0000, half_lane};
      DM_BYTE:   ld_data_o = {{24{byte_lane[7]}}, byte_lane};
      DM_BYTE_U: ld_data_o = {24'h000000, byte_lane};
      default:   ld_data_o = ld_data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one word-aligned req/ack bus access per instruction, >=2 stall cycles.
// Holds the pipeline via stall_o until ack or timeout; result shown for one DONE cycle.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  DMType_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dout,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  lsu_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, load_q, load_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, cnt_q, cnt_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;

  logic        access;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  assign access = valid_i & (MemRead_i | MemWrite_i);

  lsu_align u_align (
    .st_type_i (DMType_i),
    .st_off_i  (addr_i[1:0]),
    .st_data_i (wdata_i),
    .st_be_o   (st_be),
    .st_data_o (st_data),
    .ld_type_i (type_q),
    .ld_off_i  (off_q),
    .ld_data_i (mem_rdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    type_d     = type_q;
    off_d      = off_q;
    load_d     = load_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = 32'd0;
        err_d  = 1'b0;
        data_d = 32'd0;
        if (access) begin
          if (is_misaligned(DMType_i, addr_i[1:0])) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            req_d   = 1'b1;
            // A load wins when both read and write are flagged.
            we_d    = ~MemRead_i;
            load_d  = MemRead_i;
            addr_d  = {addr_i[31:2], 2'b00};
            wdata_d = MemRead_i ? 32'd0 : st_data;
            be_d    = st_be;
            type_d  = DMType_i;
            off_d   = addr_i[1:0];
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        if (mem_ack) begin
          req_d   = 1'b0;
          data_d  = load_q ? ld_data : 32'd0;
          state_d = DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
          req_d   = 1'b0;
          data_d  = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      type_q  <= DM_WORD;
      off_q   <= 2'd0;
      load_q  <= 1'b0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      type_q  <= type_d;
      off_q   <= off_d;
      load_q  <= load_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign dout      = (state_q == DONE) ? data_q : 32'd0;
  assign bus_err_o = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, hand sequences, randomized model.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_i, MemRead_i, MemWrite_i;
  logic [2:0]  DMType_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] dout;
  logic        stall_o, misalign_o, bus_err_o;

  int n_chk  = 0;
  int n_pass = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .DMType_i(DMType_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dout(dout), .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          ack_at;   // BUSY cycle in which ack arrives; 0 = never
    logic        mis;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] edout;
    int          busy;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    DMType_i = DM_WORD; addr_i = 32'd0; wdata_i = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  // Reference model derived from access size arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int size;
    logic sgn;
    logic [31:0] mask, lane;
    logic load;
    case (v.ty)
      DM_HALF:   begin size = 2; sgn = 1'b1; end
      DM_HALF_U: begin size = 2; sgn = 1'b0; end
      DM_BYTE:   begin size = 1; sgn = 1'b1; end
      DM_BYTE_U: begin size = 1; sgn = 1'b0; end
      default:   begin size = 4; sgn = 1'b0; end
    endcase
    mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    load = v.rd;
    r.mis = (size == 2 && v.addr[0]) || (size == 4 && v.addr[1:0] != 2'b00);
    r.be  = 4'((32'd1 << size) - 32'd1) << v.addr[1:0];
    r.ewd = (size == 4) ? v.wd : (size == 2) ? (v.wd & mask) * 32'h0001_0001
                                            : (v.wd & mask) * 32'h0101_0101;
    lane = (v.rdat >> (8 * v.addr[1:0])) & mask;
    if (sgn && ((lane & ~(mask >> 1)) != 0)) lane = lane | ~mask;
    r.err   = !(v.ack_at >= 1 && v.ack_at <= TO);
    r.busy  = r.err ? TO : v.ack_at;
    r.edout = (r.err || !load) ? 32'd0 : lane;
    return r;
  endfunction

  task automatic run_access(input vec_t v, input string nm);
    int  busy = 0;
    int  stalls = 0;
    bit  done = 0;
    logic exp_we = ~v.rd;
    @(negedge clk);
    valid_i = 1'b1; MemRead_i = v.rd; MemWrite_i = v.wr; DMType_i = v.ty;
    addr_i = v.addr; wdata_i = v.wd; mem_ack = 1'b0;
    #1;
    chk({nm, " issue misalign"}, 32'(misalign_o), 32'(v.mis));
    chk({nm, " issue req"}, 32'(mem_req), 32'd0);
    chk({nm, " issue dout"}, dout, 32'd0);
    if (v.mis) begin
      chk({nm, " mis stall"}, 32'(stall_o), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk({nm, " mis no req"}, 32'(mem_req), 32'd0);
      chk({nm, " mis pulse end"}, 32'(misalign_o), 32'd0);
      return;
    end
    if (stall_o) stalls++;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      if (stall_o) begin
        busy++; stalls++;
        chk({nm, " req"}, 32'(mem_req), 32'd1);
        chk({nm, " we"}, 32'(mem_we), 32'(exp_we));
        chk({nm, " addr"}, mem_addr, {v.addr[31:2], 2'b00});
        chk({nm, " be"}, 32'(mem_be), 32'(v.be));
        if (exp_we) chk({nm, " wdata"}, mem_wdata, v.ewd);
        if (busy == v.ack_at) begin mem_ack = 1'b1; mem_rdata = v.rdat; end
      end else begin
        done = 1;
        chk({nm, " stall cycles"}, 32'(stalls), 32'(v.busy + 1));
        chk({nm, " dout"}, dout, v.edout);
        chk({nm, " bus_err"}, 32'(bus_err_o), 32'(v.err));
        chk({nm, " req dropped"}, 32'(mem_req), 32'd0);
        idle_inputs();
      end
    end
    if (!done) chk({nm, " completion within bound"}, 32'd0, 32'd1);
    @(negedge clk);
    #1;
    chk({nm, " idle dout"}, dout, 32'd0);
    chk({nm, " idle bus_err"}, 32'(bus_err_o), 32'd0);
    chk({nm, " idle stall"}, 32'(stall_o), 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    //            rd  wr  ty         addr          wd            rdat          ack mis be       ewd           dout          busy err
    vecs[0]  = '{1'b1,1'b0,DM_WORD,  32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0,4'b1111,32'h0,        32'hDEADBEEF, 3, 1'b0};
    vecs[1]  = '{1'b1,1'b0,DM_BYTE,  32'h203, 32'h0,        32'h80000000, 1, 1'b0,4'b1000,32'h0,        32'hFFFFFF80, 1, 1'b0};
    vecs[2]  = '{1'b1,1'b0,DM_BYTE_U,32'h203, 32'h0,        32'h80000000, 1, 1'b0,4'b1000,32'h0,        32'h00000080, 1, 1'b0};
    vecs[3]  = '{1'b0,1'b1,DM_HALF,  32'h042, 32'h1234ABCD, 32'h55555555, 2, 1'b0,4'b1100,32'hABCDABCD, 32'h0,        2, 1'b0};
    vecs[4]  = '{1'b1,1'b0,DM_WORD,  32'h102, 32'h0,        32'h0,        1, 1'b1,4'b0000,32'h0,        32'h0,        0, 1'b0};
    vecs[5]  = '{1'b1,1'b0,DM_WORD,  32'h300, 32'h0,        32'h12345678, 0, 1'b0,4'b1111,32'h0,        32'h0,        4, 1'b1};
    vecs[6]  = '{1'b1,1'b0,DM_HALF,  32'h102, 32'h0,        32'h80011234, 1, 1'b0,4'b1100,32'h0,        32'hFFFF8001, 1, 1'b0};
    vecs[7]  = '{1'b1,1'b0,DM_HALF_U,32'h100, 32'h0,        32'h1234F00D, 2, 1'b0,4'b0011,32'h0,        32'h0000F00D, 2, 1'b0};
    vecs[8]  = '{1'b0,1'b1,DM_BYTE,  32'h011, 32'h000000A5, 32'h0,        1, 1'b0,4'b0010,32'hA5A5A5A5, 32'h0,        1, 1'b0};
    vecs[9]  = '{1'b0,1'b1,DM_WORD,  32'h020, 32'hCAFEF00D, 32'h0,        4, 1'b0,4'b1111,32'hCAFEF00D, 32'h0,        4, 1'b0};
    vecs[10] = '{1'b1,1'b0,DM_HALF,  32'h101, 32'h0,        32'h0,        1, 1'b1,4'b0000,32'h0,        32'h0,        0, 1'b0};
    vecs[11] = '{1'b1,1'b1,DM_WORD,  32'h040, 32'h11111111, 32'h0BADF00D, 1, 1'b0,4'b1111,32'h0,        32'h0BADF00D, 1, 1'b0};
    vecs[12] = '{1'b0,1'b1,DM_BYTE,  32'h013, 32'h000000C3, 32'h0,        2, 1'b0,4'b1000,32'hC3C3C3C3, 32'h0,        2, 1'b0};

    idle_inputs();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset req", 32'(mem_req), 32'd0);
    chk("reset we", 32'(mem_we), 32'd0);
    chk("reset addr", mem_addr, 32'd0);
    chk("reset be", 32'(mem_be), 32'd0);
    chk("reset wdata", mem_wdata, 32'd0);
    chk("reset dout", dout, 32'd0);
    chk("reset flags", {29'd0, stall_o, misalign_o, bus_err_o}, 32'd0);

    for (int i = 0; i < 13; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Stray ack and a valid non-memory instruction while idle.
    @(negedge clk);
    valid_i = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("nonmem stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stray ack req", 32'(mem_req), 32'd0);
    chk("stray ack dout", dout, 32'd0);

    // Reset asserted while BUSY, followed by a late ack.
    @(negedge clk);
    valid_i = 1'b1; MemRead_i = 1'b1; DMType_i = DM_WORD; addr_i = 32'h500;
    @(negedge clk);
    #1;
    chk("rst-mid req", 32'(mem_req), 32'd1);
    idle_inputs();
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    #1;
    chk("rst-mid req dropped", 32'(mem_req), 32'd0);
    chk("rst-mid stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst-mid late ack dout", dout, 32'd0);
    chk("rst-mid late ack req", 32'(mem_req), 32'd0);
    chk("rst-mid bus_err", 32'(bus_err_o), 32'd0);

    for (int i = 0; i < 60; i++) begin
      vec_t v;
      int k = int'($urandom_range(0, 2));
      v.rd = (k != 1); v.wr = (k != 0);
      v.ty = 3'($urandom_range(0, 4));
      v.addr = $urandom; v.wd = $urandom; v.rdat = $urandom;
      v.ack_at = int'($urandom_range(0, TO + 1));
      v = model(v);
      run_access(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the pipelined CPU.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Converts one memory instruction per issue into a single word-aligned request on a req/ack data-memory bus, with byte-enables.
- Aligns and sign/zero-extends load data into dout for MEM/WB; holds the pipeline with stall_o while the access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  synchronous, active-high reset (asserted = 1), sampled on the rising edge of clk
- valid_i  in  1  instruction in MEM is valid
- MemRead_i  in  1  instruction is a load
- MemWrite_i  in  1  instruction is a store
- DMType_i  in  3  access size/sign (package encoding)
- addr_i  in  32  effective byte address from the ALU
- wdata_i  in  32  store data (rs2)
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  one-cycle completion strobe
- mem_rdata  in  32  read word; valid in the mem_ack cycle
- dout  out  32  aligned and extended load result to MEM/WB
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign_o  out  1  one-cycle misaligned-access flag
- bus_err_o  out  1  one-cycle timeout flag

Behaviour:
- Access = valid_i & (MemRead_i | MemWrite_i). If both are set, treat it as a load.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Byte accesses are never misaligned.
- States:
  - IDLE, access aligned: latch the bus fields, assert stall_o (combinational), go to BUSY.
  - IDLE, access misaligned: misalign_o=1 for that cycle; no stall, no bus activity, dout=0, stay IDLE.
  - BUSY: mem_req=1 with stable fields; stall_o=1. Timeout counter increments each cycle.
    - On mem_ack: capture aligned load data (stores capture 0), mem_req=0 next cycle, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES without ack: drop mem_req, dout=0, bus_err_o=1 in the DONE cycle, go to DONE.
  - DONE: stall_o=0, dout holds the captured value so MEM/WB latches it. Go to IDLE unconditionally; the same instruction is never re-issued.
- Latency: minimum 2 stall cycles (issue cycle plus an ack in the first BUSY cycle); result is visible in DONE.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered, and are constant from the first BUSY cycle until ack.
- Store byte enables (unsigned DMTypes act as their signed size):
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{wdata_i[7:0]}}
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata_i[15:0]}}
  - word: be = 4'b1111, wdata = wdata_i
- Load extraction: select the byte lane addr[1:0] or halfword lane addr[1], then sign-extend (signed types) or zero-extend (unsigned types).
- dout is 0 when there is no access and in IDLE.
- mem_ack outside BUSY is ignored.
- Reset values: state=IDLE, all bus outputs 0, dout=0, flags 0, counter 0.
- Reset mid-access: return to IDLE next edge and drop mem_req; a late ack is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - DMType constants: DM_WORD=3'b000, DM_HALF=3'b001, DM_HALF_U=3'b010, DM_BYTE=3'b011, DM_BYTE_U=3'b100
  - the state enum (IDLE/BUSY/DONE)
- One combinational sub-module, lsu_align: store lane/byte-enable generation and load extract/extend.

Test Plan:
- LW addr=0x100, ack after 3 BUSY cycles, rdata=0xDEADBEEF -> mem_addr=0x100, be=4'hF, stall high 4 cycles, dout=0xDEADBEEF in DONE.
- LB addr=0x203, rdata=0x80000000 -> be=4'b1000, dout=0xFFFFFF80. Same with LBU -> dout=0x00000080.
- SH addr=0x42, wdata_i=0x1234ABCD -> mem_we=1, be=4'b1100, mem_wdata=0xABCDABCD, dout=0.
- LW addr=0x102 -> misalign_o pulse, stall_o=0, mem_req never asserted.
- TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, bus_err_o=1 in DONE, dout=0.
- rstn=1 during BUSY, then ack one cycle later -> state IDLE, mem_req=0, ack ignored, dout stays 0.
